// File: rtl/match_sequencer.sv
// Frame sequencer for the template-matching datapath: template pass, window pass,
// then write-back of the best NCC/index over the shared memory port, repeated per set.
module match_sequencer #(
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned ROW_W    = 7,
  parameter int unsigned NCC_W    = 64,
  parameter int unsigned IDX_W    = 13,
  parameter int unsigned WB_WORDS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_W-1:0]     cfg_num_sets,
  output logic                   tmpl_en,
  input  logic                   tmpl_done,
  input  logic [ROW_W-1:0]       tmpl_row,
  input  logic [ROW_W-1:0]       tmpl_col,
  output logic                   win_en,
  input  logic                   win_done,
  input  logic [ROW_W-1:0]       win_row,
  input  logic [ROW_W-1:0]       win_col,
  input  logic [NCC_W-1:0]       result_ncc,
  input  logic [IDX_W-1:0]       result_idx,
  output logic                   req,
  output logic                   rd_wr,
  output logic                   tem_win,
  output logic [ROW_W-1:0]       row,
  output logic [ROW_W-1:0]       col,
  output logic [31:0]            write_data,
  output logic [((WB_WORDS > 1) ? $clog2(WB_WORDS) : 1)-1:0] wr_index,
  input  logic                   mem_gnt,
  output logic                   busy,
  output logic                   set_done,
  output logic [COUNT_W-1:0]     set_count
);

  localparam int unsigned WI_W    = (WB_WORDS > 1) ? $clog2(WB_WORDS) : 1;
  localparam int unsigned WB_BITS = 32 * WB_WORDS;
  localparam int unsigned PAD_W   = WB_BITS - NCC_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TEMP  = 3'd1,
    S_WIND  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                       state_q, state_d;
  logic [COUNT_W-1:0]           set_count_q, set_count_d;
  logic [COUNT_W-1:0]           num_sets_q, num_sets_d;
  logic [WB_WORDS-1:0][31:0]    wb_buf_q, wb_buf_d;
  logic [WI_W-1:0]              word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      set_count_q <= '0;
      num_sets_q  <= '0;
      wb_buf_q    <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      set_count_q <= set_count_d;
      num_sets_q  <= num_sets_d;
      wb_buf_q    <= wb_buf_d;
      word_q      <= word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_count_d = set_count_q;
    num_sets_d  = num_sets_q;
    wb_buf_d    = wb_buf_q;
    word_d      = word_q;
    tmpl_en     = 1'b0;
    win_en      = 1'b0;
    req         = 1'b0;
    rd_wr       = 1'b0;
    tem_win     = 1'b0;
    row         = '0;
    col         = '0;
    write_data  = '0;
    wr_index    = '0;
    set_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tmpl_en     = 1'b1;
          req         = 1'b1;
          row         = tmpl_row;
          col         = tmpl_col;
          set_count_d = '0;
          num_sets_d  = cfg_num_sets;
          state_d     = (cfg_num_sets == '0) ? S_DONE : S_TEMP;
        end
      end

      S_TEMP: begin
        req = 1'b1;
        if (!tmpl_done) begin
          tmpl_en = 1'b1;
          row     = tmpl_row;
          col     = tmpl_col;
        end else begin
          win_en  = 1'b1;
          tem_win = 1'b1;
          row     = win_row;
          col     = win_col;
          state_d = S_WIND;
        end
      end

      S_WIND: begin
        if (!win_done) begin
          win_en  = 1'b1;
          req     = 1'b1;
          tem_win = 1'b1;
          row     = win_row;
          col     = win_col;
        end else begin
          // Result packed MSB-first so word 0 carries the zero pad.
          wb_buf_d    = WB_BITS'({result_ncc, result_idx}) << PAD_W;
          set_count_d = set_count_q + COUNT_W'(1);
          word_d      = '0;
          state_d     = S_WRITE;
        end
      end

      S_WRITE: begin
        req        = 1'b1;
        rd_wr      = 1'b1;
        wr_index   = word_q;
        write_data = wb_buf_q[word_q];
        if (mem_gnt) begin
          word_d = word_q + WI_W'(1);
          if (word_q == WI_W'(WB_WORDS - 1)) begin
            word_d = '0;
            if (set_count_q == num_sets_q) begin
              state_d = S_DONE;
            end else begin
              // Overlap the next template presentation with the final granted beat.
              tmpl_en = 1'b1;
              row     = tmpl_row;
              col     = tmpl_col;
              state_d = S_TEMP;
            end
          end
        end
      end

      S_DONE: begin
        set_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      set_count_d = '0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign set_count = set_count_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed self-checking bench for match_sequencer.
module tb_match_sequencer;

  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned ROW_W    = 7;
  localparam int unsigned NCC_W    = 64;
  localparam int unsigned IDX_W    = 13;
  localparam int unsigned WB_WORDS = 3;
  localparam int unsigned WI_W     = 2;
  localparam int unsigned PAD_W    = 32 * WB_WORDS - NCC_W - IDX_W;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [COUNT_W-1:0] cfg_num_sets;
  logic               tmpl_en;
  logic               tmpl_done;
  logic [ROW_W-1:0]   tmpl_row;
  logic [ROW_W-1:0]   tmpl_col;
  logic               win_en;
  logic               win_done;
  logic [ROW_W-1:0]   win_row;
  logic [ROW_W-1:0]   win_col;
  logic [NCC_W-1:0]   result_ncc;
  logic [IDX_W-1:0]   result_idx;
  logic               req;
  logic               rd_wr;
  logic               tem_win;
  logic [ROW_W-1:0]   row;
  logic [ROW_W-1:0]   col;
  logic [31:0]        write_data;
  logic [WI_W-1:0]    wr_index;
  logic               mem_gnt;
  logic               busy;
  logic               set_done;
  logic [COUNT_W-1:0] set_count;

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  match_sequencer #(
    .COUNT_W(COUNT_W), .ROW_W(ROW_W), .NCC_W(NCC_W), .IDX_W(IDX_W), .WB_WORDS(WB_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_num_sets(cfg_num_sets),
    .tmpl_en(tmpl_en), .tmpl_done(tmpl_done), .tmpl_row(tmpl_row), .tmpl_col(tmpl_col),
    .win_en(win_en), .win_done(win_done), .win_row(win_row), .win_col(win_col),
    .result_ncc(result_ncc), .result_idx(result_idx),
    .req(req), .rd_wr(rd_wr), .tem_win(tem_win), .row(row), .col(col),
    .write_data(write_data), .wr_index(wr_index), .mem_gnt(mem_gnt),
    .busy(busy), .set_done(set_done), .set_count(set_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Granted write beats, sampled mid-cycle.
  always @(negedge clk) if (rst_n && req && rd_wr && mem_gnt) beats++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [COUNT_W-1:0] n);
    start = 1'b1;
    cfg_num_sets = n;
    #1;
    chk("start_tmpl_en", tmpl_en, 1);
    chk("start_req", req, 1);
    chk("start_row", row, tmpl_row);
    step();
    start = 1'b0;
  endtask

  task automatic temp_phase(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("temp_tmpl_en", tmpl_en, 1);
      chk("temp_tem_win", tem_win, 0);
      chk("temp_col", col, tmpl_col);
      step();
    end
    tmpl_done = 1'b1;
    #1;
    chk("tdone_win_en", win_en, 1);
    chk("tdone_tmpl_en", tmpl_en, 0);
    chk("tdone_tem_win", tem_win, 1);
    chk("tdone_row", row, win_row);
    step();
    tmpl_done = 1'b0;
  endtask

  task automatic wind_phase(input int n, input logic [NCC_W-1:0] ncc, input logic [IDX_W-1:0] idx);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("wind_win_en", win_en, 1);
      chk("wind_req", req, 1);
      chk("wind_col", col, win_col);
      step();
    end
    win_done   = 1'b1;
    result_ncc = ncc;
    result_idx = idx;
    #1;
    chk("wdone_win_en", win_en, 0);
    chk("wdone_req", req, 0);
    step();
    win_done   = 1'b0;
    result_ncc = ~ncc;
    result_idx = ~idx;
  endtask

  task automatic write_phase(input logic [32*WB_WORDS-1:0] full, input int exp_cnt,
                             input int stall_word, input int stall_len, input bit last);
    for (int w = 0; w < WB_WORDS; w++) begin
      if (w == stall_word) begin
        for (int s = 0; s < stall_len; s++) begin
          mem_gnt = 1'b0;
          #1;
          chk("stall_index", wr_index, w);
          chk("stall_data", write_data, full[32*w +: 32]);
          chk("stall_req_wr", {req, rd_wr}, 2'b11);
          step();
        end
      end
      mem_gnt = 1'b1;
      #1;
      chk("wr_index", wr_index, w);
      chk("wr_data", write_data, full[32*w +: 32]);
      chk("wr_req_wr", {req, rd_wr}, 2'b11);
      chk("wr_set_count", set_count, exp_cnt);
      if (w == WB_WORDS - 1 && !last) chk("wr_next_tmpl_en", tmpl_en, 1);
      step();
    end
    mem_gnt = 1'b0;
    if (last) begin
      #1;
      chk("done_pulse", set_done, 1);
      chk("done_busy", busy, 1);
      chk("done_count", set_count, exp_cnt);
      chk("done_req", req, 0);
      step();
      #1;
      chk("after_done_pulse", set_done, 0);
      chk("after_done_busy", busy, 0);
      chk("after_done_count", set_count, exp_cnt);
      step();
    end
  endtask

  initial begin
    logic [NCC_W-1:0] n;
    logic [IDX_W-1:0] x;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_num_sets = '0;
    tmpl_done = 1'b0; win_done = 1'b0; mem_gnt = 1'b0;
    tmpl_row = 7'd5; tmpl_col = 7'd6; win_row = 7'd17; win_col = 7'd18;
    result_ncc = '0; result_idx = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {tmpl_en, win_en, req, rd_wr, tem_win, set_done}, 0);
    chk("rst_addr_data", {row, col, write_data, wr_index}, 0);
    chk("rst_count", set_count, 0);
    rst_n = 1'b1;
    step();
    chk("idle_req", req, 0);

    // Two-set frame with a stalled write on the second set.
    beats = 0;
    do_start(8'd2);
    temp_phase(3);
    wind_phase(3, 64'h0000_0001_8000_0000, 13'h1ABC);
    write_phase(96'h0000_0001_8000_0000_D5E0_0000, 1, -1, 0, 1'b0);
    n = 64'hFEDC_BA98_7654_3210; x = 13'h0F0F;
    temp_phase(3);
    wind_phase(3, n, x);
    write_phase({n, x, {PAD_W{1'b0}}}, 2, 1, 5, 1'b1);
    chk("frame1_beats", beats, 6);

    // Zero-set frame.
    do_start(8'd0);
    #1;
    chk("zero_done", set_done, 1);
    chk("zero_req", {req, tmpl_en}, 0);
    chk("zero_count", set_count, 0);
    step();
    #1;
    chk("zero_after_done", set_done, 0);
    chk("zero_after_busy", busy, 0);
    step();

    // Abort in WIND of set 3 of 5, then a full 5-set frame.
    do_start(8'd5);
    for (int s = 1; s <= 2; s++) begin
      n = 64'h1111_0000_0000_0000 * s; x = 13'(s * 3);
      temp_phase(1);
      wind_phase(1, n, x);
      write_phase({n, x, {PAD_W{1'b0}}}, s, -1, 0, 1'b0);
    end
    temp_phase(1);
    #1;
    chk("pre_abort_win_en", win_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_count", set_count, 0);
    chk("abort_no_done", set_done, 0);
    step();
    #1;
    chk("abort_no_done2", set_done, 0);
    step();
    do_start(8'd5);
    for (int s = 1; s <= 5; s++) begin
      n = {32'(s), 32'hA5A5_0000}; x = 13'(s * 100);
      temp_phase(2);
      wind_phase(1, n, x);
      write_phase({n, x, {PAD_W{1'b0}}}, s, -1, 0, (s == 5));
    end

    // tmpl_done and win_done together in TEMP, then reset mid-WRITE.
    do_start(8'd1);
    tmpl_done = 1'b1; win_done = 1'b1; result_ncc = 64'hDEAD; result_idx = 13'h1;
    #1;
    chk("both_win_en", win_en, 1);
    step();
    tmpl_done = 1'b0; win_done = 1'b0;
    #1;
    chk("both_wait1", win_en, 1);
    chk("both_busy", busy, 1);
    step();
    #1;
    chk("both_wait2", win_en, 1);
    step();
    win_done = 1'b1; result_ncc = 64'h0123_4567_89AB_CDEF; result_idx = 13'h0002;
    #1;
    step();
    win_done = 1'b0;
    mem_gnt = 1'b1;
    #1;
    chk("rw_word0", write_data, 32'h0010_0000);
    step();
    mem_gnt = 1'b0;
    #1;
    chk("rw_word1_idx", wr_index, 1);
    chk("rw_word1_data", write_data, 32'h89AB_CDEF);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {tmpl_en, win_en, req, rd_wr, tem_win, set_done, busy}, 0);
    chk("midrst_data", {row, col, write_data, wr_index}, 0);
    chk("midrst_count", set_count, 0);
    #3;
    rst_n = 1'b1;
    step();
    #1;
    chk("post_rst_idle", {busy, req}, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
